// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: delays writeback fields to line up with commit, compacts valid lanes
// into a sequence-numbered FIFO, and sequences the core reset. Optional macro: COMMIT_TRACE_X0_FILTER_EN.
module commit_trace_buffer #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned WB_DELAY = 1,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RST_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  core_rst,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES*64-1:0]   in_pc,
    input  logic [LANES*32-1:0]   in_inst,
    input  logic [LANES-1:0]      in_skip,
    input  logic [LANES-1:0]      in_wen,
    input  logic [LANES*5-1:0]    in_wdest,
    input  logic [LANES*64-1:0]   in_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_pc,
    output logic [31:0]           out_inst,
    output logic                  out_skip,
    output logic                  out_wen,
    output logic [7:0]            out_wdest,
    output logic [63:0]           out_wdata,
    output logic [31:0]           out_seq,
    output logic                  stall_req,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    output logic [63:0]           cycle_cnt
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned HW  = 4;
    localparam int unsigned WBW = LANES * (1 + 5 + 64);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic [31:0] seq;
    } entry_t;

    typedef enum logic {S_HOLD = 1'b0, S_RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;

    // Reset sequencer: hold the core in reset for RST_HOLD edges after release.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_HOLD: begin
                if (hold_q == HW'(RST_HOLD - 1)) state_d = S_RUN;
                else                             hold_d  = hold_q + HW'(1);
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_HOLD;
        endcase
    end

    assign core_rst = (state_q == S_HOLD);

    logic [LANES-1:0]    dwen;
    logic [LANES*5-1:0]  dwdest;
    logic [LANES*64-1:0] dwdata;

    if (WB_DELAY == 0) begin : g_wb_pass
        assign {dwen, dwdest, dwdata} = {in_wen, in_wdest, in_wdata};
    end else begin : g_wb_dly
        logic [WBW-1:0] wb_q [WB_DELAY];
        logic [WBW-1:0] wb_d [WB_DELAY];

        // Shift line freezes while the core is held in reset.
        always_comb begin
            for (int i = 0; i < WB_DELAY; i++) wb_d[i] = wb_q[i];
            if (!core_rst) begin
                wb_d[0] = {in_wen, in_wdest, in_wdata};
                for (int i = 1; i < WB_DELAY; i++) wb_d[i] = wb_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < WB_DELAY; i++) wb_q[i] <= '0;
            end else begin
                for (int i = 0; i < WB_DELAY; i++) wb_q[i] <= wb_d[i];
            end
        end

        assign {dwen, dwdest, dwdata} = wb_q[WB_DELAY-1];
    end

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   seq_q, seq_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [63:0]   cyc_q, cyc_d;

    logic [PW-1:0] used_c, free_c, nvalid_c, slot_c;
    logic          push_c, reject_c, pop_c;
    logic [16:0]   drop_sum_c;
    logic [AW-1:0] widx_c;
    entry_t        ent_c, head_c;

    assign used_c    = wr_q - rd_q;
    assign free_c    = PW'(DEPTH) - used_c;
    assign out_valid = (used_c != '0);
    assign pop_c     = out_valid && out_ready;
    assign stall_req = (free_c < PW'(2 * LANES));
    assign push_c    = !core_rst && (nvalid_c != '0) && (nvalid_c <= free_c);
    assign reject_c  = !core_rst && (nvalid_c > free_c);

    always_comb begin
        nvalid_c = '0;
        for (int l = 0; l < LANES; l++) nvalid_c = nvalid_c + PW'(in_valid[l]);
    end

    // Admission is all-or-nothing against the free count at cycle start.
    always_comb begin
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        seq_d      = seq_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        cyc_d      = cyc_q;
        slot_c     = '0;
        widx_c     = '0;
        ent_c      = '0;
        drop_sum_c = 17'(drop_q) + 17'(nvalid_c);
        if (push_c) begin
            for (int l = 0; l < LANES; l++) begin
                if (in_valid[l]) begin
                    ent_c.pc    = in_pc[l*64 +: 64];
                    ent_c.inst  = in_inst[l*32 +: 32];
                    ent_c.skip  = in_skip[l];
                    ent_c.wen   = dwen[l];
                    ent_c.wdest = {3'b000, dwdest[l*5 +: 5]};
                    ent_c.wdata = dwdata[l*64 +: 64];
                    ent_c.seq   = seq_q + 32'(slot_c);
`ifdef COMMIT_TRACE_X0_FILTER_EN
                    if (ent_c.wen && (ent_c.wdest == 8'd0)) begin
                        ent_c.wen   = 1'b0;
                        ent_c.wdata = '0;
                    end
`endif
                    widx_c         = AW'(wr_q + slot_c);
                    mem_d[widx_c]  = ent_c;
                    slot_c         = slot_c + PW'(1);
                end
            end
            wr_d  = wr_q + nvalid_c;
            seq_d = seq_q + 32'(nvalid_c);
        end
        if (reject_c) begin
            ovf_d  = 1'b1;
            drop_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
        end
        if (pop_c) rd_d = rd_q + PW'(1);
        if (state_q == S_RUN) cyc_d = cyc_q + 64'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            cyc_q   <= cyc_d;
        end
    end

    assign head_c    = mem_q[rd_q[AW-1:0]];
    assign out_pc    = out_valid ? head_c.pc    : '0;
    assign out_inst  = out_valid ? head_c.inst  : '0;
    assign out_skip  = out_valid ? head_c.skip  : 1'b0;
    assign out_wen   = out_valid ? head_c.wen   : 1'b0;
    assign out_wdest = out_valid ? head_c.wdest : '0;
    assign out_wdata = out_valid ? head_c.wdata : '0;
    assign out_seq   = out_valid ? head_c.seq   : '0;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;
    assign cycle_cnt = cyc_q;

endmodule
